// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width and the
// sequencing states used by the bit-serial ALU blocks.
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } sub_state_e;

endpackage

// File: rtl/half_subtractor_1b.sv
// One-bit half subtractor.
// Ports: x, y in; diff = x^y, borrow = ~x&y out.
module half_subtractor_1b (
    input  logic x,
    input  logic y,
    output logic diff,
    output logic borrow
);

    assign diff   = x ^ y;
    assign borrow = ~x & y;

endmodule

// File: rtl/serial_subtractor_8b.sv
// Bit-serial subtractor, diff = a - b, LSB first, one bit per clock.
// Ports: clk, rst_n, start, a, b in; busy, done, diff, borrow_out,
// zero, overflow out (all registered).
module serial_subtractor_8b
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH) + 1;

    sub_state_e       state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic [CW-1:0]    cnt_q;
    logic             brw_q;
    logic             brw_d;
    logic             busy_q;
    logic             done_q;
    logic             zero_q;
    logic             ovf_q;

    logic p_diff;
    logic p_brw;
    logic bit_d;
    logic q_brw;
    logic last_bit;

    // Full subtractor from two half subtractors: operand bits first,
    // then the partial difference against the stored borrow.
    half_subtractor_1b u_hs_op (
        .x      (a_q[0]),
        .y      (b_q[0]),
        .diff   (p_diff),
        .borrow (p_brw)
    );

    half_subtractor_1b u_hs_brw (
        .x      (p_diff),
        .y      (brw_q),
        .diff   (bit_d),
        .borrow (q_brw)
    );

    assign brw_d    = p_brw | q_brw;
    assign res_d    = {bit_d, res_q[WIDTH-1:1]};
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        brw_q   <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    res_q <= res_d;
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    brw_q <= brw_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_bit) begin
                        // Operand MSBs sit in bit 0 on the final step.
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        zero_q  <= (res_d == '0);
                        ovf_q   <= (a_q[0] ^ b_q[0])
                                 & (a_q[0] ^ bit_d);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = res_q;
    assign borrow_out = brw_q;
    assign zero       = zero_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor_8b.sv
// Scoreboard bench for serial_subtractor_8b: directed vectors plus
// a random sweep against a reference model.
module tb_serial_subtractor_8b;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow_out;
    logic       zero;
    logic       overflow;

    serial_subtractor_8b #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .zero       (zero),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        logic       bo;
        logic       z;
        logic       ov;
        int         c;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                e = q.pop_front();
                chk("diff", {24'd0, diff}, {24'd0, e.d});
                chk("borrow_out", {31'd0, borrow_out}, {31'd0, e.bo});
                chk("zero", {31'd0, zero}, {31'd0, e.z});
                chk("overflow", {31'd0, overflow}, {31'd0, e.ov});
                chk("latency", cyc - e.c, 32'd9);
                chk("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
    endtask

    task automatic issue(input logic [7:0] ta, input logic [7:0] tb,
                         input logic [7:0] ed, input logic ebo,
                         input logic ez, input logic eov,
                         input bit push);
        @(negedge clk);
        a     = ta;
        b     = tb;
        start = 1'b1;
        if (push) q.push_back('{ed, ebo, ez, eov, cyc});
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    task automatic run(input logic [7:0] ta, input logic [7:0] tb,
                       input logic [7:0] ed, input logic ebo,
                       input logic ez, input logic eov);
        wait_idle();
        issue(ta, tb, ed, ebo, ez, eov, 1'b1);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_diff"}, {24'd0, diff}, 32'd0);
        chk({tag, "_borrow"}, {31'd0, borrow_out}, 32'd0);
        chk({tag, "_zero"}, {31'd0, zero}, 32'd0);
        chk({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic [8:0] s;
        int         n;

        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        rst_n = 1'b1;

        run(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0);
        run(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0);
        run(8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1);
        run(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b1);
        run(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0);
        run(8'h00, 8'h80, 8'h80, 1'b1, 1'b0, 1'b1);

        // Back-to-back with noise on the inputs during SHIFT.
        run(8'h3C, 8'h3C, 8'h00, 1'b0, 1'b1, 1'b0);
        a = 8'h11;
        b = 8'h22;
        repeat (3) begin
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("first_done_seen", {31'd0, done}, 32'd1);
        a     = 8'hA5;
        b     = 8'h5A;
        start = 1'b1;
        q.push_back('{8'h4B, 1'b0, 1'b0, 1'b1, cyc});
        @(negedge clk);
        start = 1'b0;
        chk("b2b_accept", {31'd0, busy}, 32'd1);

        // Reset during bit 4 discards the operation.
        wait_idle();
        issue(8'hF0, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        run(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            s  = {1'b0, ra} - {1'b0, rb};
            run(ra, rb, s[7:0], s[8], s[7:0] == 8'h00,
                (ra[7] ^ rb[7]) & (ra[7] ^ s[7]));
        end

        n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
